posit_product_encode_es2: RTL and testbench

- Pipelined posit encoder: converts a serialized raw product value (sign, scale, hidden-bit-free fraction, inf, zero) into a 32-bit es=2 posit with round-to-nearest-even.
- Sits downstream of the raw posit multipliers. It turns their serialized product output back into a packed posit word for storage and host readback.
- Fully pipelined: accepts one value per cycle, fixed latency, no backpressure.

---
 rtl/posit_product_encode_es2_if.sv | 13 +
 rtl/posit_product_encode_es2.sv | 109 ++++++++++
 tb/tb_posit_product_encode_es2.sv | 124 ++++++++++++
 3 files changed

// File: rtl/posit_product_encode_es2_if.sv
// Product-to-posit encoder bus: serialized raw product in, packed posit out.
interface posit_product_encode_es2_if #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned IN_W  = 67
);
  logic [IN_W-1:0]  in1;
  logic             start;
  logic [NBITS-1:0] result;
  logic             done;

  modport master (output in1, output start, input result, input done);
  modport slave  (input in1, input start, output result, output done);
endinterface

// File: rtl/posit_product_encode_es2.sv
// Three-stage encoder from a raw {sgn, scale, fraction, inf, zero} product
// to an es=2 posit word with round-to-nearest-even and saturation.
module posit_product_encode_es2 #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned ES    = 2,
  parameter int unsigned SBITS = 8,
  parameter int unsigned MBITS = 56,
  parameter int unsigned IN_W  = 1 + SBITS + MBITS + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  posit_product_encode_es2_if.slave bus
);
  localparam int unsigned KEEP_W  = NBITS - 1;
  localparam int unsigned PAD_W   = NBITS - 2;
  localparam int unsigned BODY_W  = 2 + ES + MBITS + PAD_W;
  localparam int unsigned SHAMT_W = 5;
  localparam int          SCALE_MAX = 120;

  // Stage 1 registers
  logic                    s1_valid, s1_sgn, s1_inf, s1_zero;
  logic signed [SBITS-1:0] s1_scale;
  logic [MBITS-1:0]        s1_frac;

  // Stage 2 registers
  logic                    s2_valid, s2_sgn, s2_inf, s2_zero;
  logic [KEEP_W-1:0]       s2_keep;
  logic                    s2_guard, s2_sticky;

  // Stage 3 (output) registers
  logic                    done_q;
  logic [NBITS-1:0]        result_q;

  // Regime/field assembly
  logic signed [SBITS-1:0]  sc_c, k_c;
  logic                     kneg_c;
  logic [SHAMT_W-1:0]       shamt_c;
  logic signed [BODY_W-1:0] body_c;

  always_comb begin
    sc_c = s1_scale;
    if (s1_scale > $signed(SBITS'(SCALE_MAX)))
      sc_c = $signed(SBITS'(SCALE_MAX));
    else if (s1_scale < $signed(SBITS'(-SCALE_MAX)))
      sc_c = $signed(SBITS'(-SCALE_MAX));
    k_c    = sc_c >>> ES;
    kneg_c = k_c[SBITS-1];
    // For k<0 the run of zeros minus one equals ~k.
    shamt_c = kneg_c ? ~k_c[SHAMT_W-1:0] : k_c[SHAMT_W-1:0];
    body_c  = $signed({~kneg_c, kneg_c, sc_c[ES-1:0], s1_frac, {PAD_W{1'b0}}}) >>> shamt_c;
  end

  // Rounding and sign
  logic             round_up_c;
  logic [NBITS-1:0] mag_c, word_c;

  always_comb begin
    round_up_c = s2_guard & (s2_keep[0] | s2_sticky);
    mag_c      = {1'b0, s2_keep} + NBITS'(round_up_c);
    word_c     = s2_sgn ? (~mag_c + NBITS'(1)) : mag_c;
    if (s2_inf)
      word_c = {1'b1, {(NBITS-1){1'b0}}};
    else if (s2_zero)
      word_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_scale  <= '0;
      s1_frac   <= '0;
      s2_valid  <= 1'b0;
      s2_sgn    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_keep   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      // An unknown start falls into the else branch and reads as idle.
      if (bus.start) s1_valid <= 1'b1;
      else           s1_valid <= 1'b0;
      s1_sgn   <= bus.in1[IN_W-1];
      s1_scale <= $signed(bus.in1[IN_W-2 -: SBITS]);
      s1_frac  <= bus.in1[MBITS+1:2];
      s1_inf   <= bus.in1[1];
      s1_zero  <= bus.in1[0];

      s2_valid  <= s1_valid;
      s2_sgn    <= s1_sgn;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_keep   <= body_c[BODY_W-1 -: KEEP_W];
      s2_guard  <= body_c[BODY_W-1-KEEP_W];
      s2_sticky <= |body_c[BODY_W-2-KEEP_W:0];

      done_q <= s2_valid;
      if (s2_valid) result_q <= word_c;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_posit_product_encode_es2.sv
// Directed bench for posit_product_encode_es2: hand-computed posit words,
// exact 3-cycle latency, start-pattern preservation and mid-flight reset.
module tb_posit_product_encode_es2;
  localparam int unsigned NBITS = 32;
  localparam int unsigned SBITS = 8;
  localparam int unsigned MBITS = 56;
  localparam int unsigned IN_W  = 1 + SBITS + MBITS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  posit_product_encode_es2_if #(.NBITS(NBITS), .IN_W(IN_W)) bus ();

  posit_product_encode_es2 #(.NBITS(NBITS), .SBITS(SBITS), .MBITS(MBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk(input logic sgn, input int scale,
                                         input logic [MBITS-1:0] frac,
                                         input logic inf, input logic zero);
    logic [SBITS-1:0] s;
    s = SBITS'(scale);
    return {sgn, s, frac, inf, zero};
  endfunction

  // One isolated start; done must be low two negedges later and high on the third.
  task automatic run_one(input string tag, input logic [IN_W-1:0] v, input logic [31:0] exp);
    @(negedge clk); bus.in1 = v; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.in1 = '0;
    @(negedge clk); check({tag, "_early"}, 32'(bus.done), 32'd0);
    @(negedge clk); check({tag, "_done"}, 32'(bus.done), 32'd1);
    check(tag, bus.result, exp);
    @(negedge clk); check({tag, "_hold"}, bus.result, exp);
    check({tag, "_doneoff"}, 32'(bus.done), 32'd0);
  endtask

  localparam logic [MBITS-1:0] F0 = '0;
  localparam logic [MBITS-1:0] FHALF = MBITS'(1) << 55;
  localparam logic [MBITS-1:0] FTIE = MBITS'(1) << 28;

  initial begin
    logic [10:0] pat;
    logic [31:0] exp_q[$];
    logic [31:0] last;
    int j;

    bus.in1 = '0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'h0);
    rst_n = 1'b1;

    run_one("one",       mk(0, 0, F0, 0, 0),    32'h40000000);
    run_one("one_5",     mk(0, 0, FHALF, 0, 0), 32'h44000000);
    run_one("neg_one_5", mk(1, 0, FHALF, 0, 0), 32'hBC000000);
    run_one("scale5",    mk(0, 5, F0, 0, 0),    32'h64000000);
    run_one("scale_m1",  mk(0, -1, F0, 0, 0),   32'h38000000);
    run_one("tie_even",  mk(0, 0, FTIE, 0, 0),  32'h40000000);
    run_one("tie_stk",   mk(0, 0, FTIE | MBITS'(1), 0, 0), 32'h40000001);
    run_one("tie_odd",   mk(0, 0, FTIE | (MBITS'(1) << 29), 0, 0), 32'h40000002);
    run_one("maxpos",    mk(0, 127, F0, 0, 0),  32'h7FFFFFFF);
    run_one("minpos",    mk(0, -128, FHALF, 0, 0), 32'h00000001);
    run_one("neg_max",   mk(1, 127, F0, 0, 0),  32'h80000001);
    run_one("neg_min",   mk(1, -128, F0, 0, 0), 32'hFFFFFFFF);
    run_one("nar",       mk(0, 3, FHALF, 1, 1), 32'h80000000);
    run_one("zero",      mk(1, 9, FHALF, 0, 1), 32'h00000000);

    // Ten starts with a gap after the fifth; value j uses scale 4j (regime of j+1 ones).
    pat = 11'b11111011111;
    j = 0;
    last = 32'h0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check($sformatf("pipe_done%0d", i), 32'(bus.done), 32'(pat[i-3]));
        if (pat[i-3]) begin
          last = exp_q.pop_front();
          check($sformatf("pipe_res%0d", i), bus.result, last);
        end else begin
          check($sformatf("pipe_hold%0d", i), bus.result, last);
        end
      end
      if (i < 11 && pat[i]) begin
        bus.in1 = mk(0, 4 * j, F0, 0, 0);
        bus.start = 1'b1;
        exp_q.push_back(32'h80000000 - (32'h1 << (30 - j)));
        j++;
      end else begin
        bus.start = 1'b0;
      end
    end

    // Two starts, then reset one cycle later: nothing may come out.
    @(negedge clk); bus.in1 = mk(0, 8, F0, 0, 0); bus.start = 1'b1;
    @(negedge clk); bus.in1 = mk(0, 12, F0, 0, 0);
    @(negedge clk); bus.start = 1'b0; rst_n = 1'b0;
    #1;
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_result", bus.result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_quiet%0d", i), 32'(bus.done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
